// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM encoding and the key event record
// for the PS/2 keyboard controller.
package ps2_pkg;

  // Scan-code set 2 prefixes and special bytes
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  // Modifier and lock keys
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Sequencer states
  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;

  // One folded key event as presented to the consumer
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } kbd_evt_t;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Scan-code set 2 to ASCII translation for make codes. Letters follow
// shift XOR caps; digits and punctuation follow shift only.
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic       is_letter;
  logic [7:0] plain;
  logic [7:0] shifted;

  // Table lookup: letters yield their lowercase glyph, everything else a plain/shifted pair
  always_comb begin
    lower     = 8'h00;
    is_letter = 1'b0;
    plain     = 8'h00;
    shifted   = 8'h00;
    is_letter = 1'b1;
    case (code)
      8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
      8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
      8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
      default: is_letter = 1'b0;
    endcase
    case (code)
      8'h16: begin plain = 8'h31; shifted = 8'h21; end
      8'h1E: begin plain = 8'h32; shifted = 8'h40; end
      8'h26: begin plain = 8'h33; shifted = 8'h23; end
      8'h25: begin plain = 8'h34; shifted = 8'h24; end
      8'h2E: begin plain = 8'h35; shifted = 8'h25; end
      8'h36: begin plain = 8'h36; shifted = 8'h5E; end
      8'h3D: begin plain = 8'h37; shifted = 8'h26; end
      8'h3E: begin plain = 8'h38; shifted = 8'h2A; end
      8'h46: begin plain = 8'h39; shifted = 8'h28; end
      8'h45: begin plain = 8'h30; shifted = 8'h29; end
      8'h0E: begin plain = 8'h60; shifted = 8'h7E; end
      8'h4E: begin plain = 8'h2D; shifted = 8'h5F; end
      8'h55: begin plain = 8'h3D; shifted = 8'h2B; end
      8'h54: begin plain = 8'h5B; shifted = 8'h7B; end
      8'h5B: begin plain = 8'h5D; shifted = 8'h7D; end
      8'h5D: begin plain = 8'h5C; shifted = 8'h7C; end
      8'h4C: begin plain = 8'h3B; shifted = 8'h3A; end
      8'h52: begin plain = 8'h27; shifted = 8'h22; end
      8'h41: begin plain = 8'h2C; shifted = 8'h3C; end
      8'h49: begin plain = 8'h2E; shifted = 8'h3E; end
      8'h4A: begin plain = 8'h2F; shifted = 8'h3F; end
      8'h29: begin plain = 8'h20; shifted = 8'h20; end
      8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
      8'h66: begin plain = 8'h08; shifted = 8'h08; end
      8'h0D: begin plain = 8'h09; shifted = 8'h09; end
      default: begin plain = 8'h00; shifted = 8'h00; end
    endcase
  end

  // Final case selection
  always_comb begin
    if (is_letter) begin
      ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
    end else begin
      ascii = shift ? shifted : plain;
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Pops bytes from the PS/2 receiver FIFO, folds E0/F0/E1 prefixes into
// single key events, tracks modifiers and Caps Lock, and offers each event
// with its ASCII translation to the consumer.
//
// Handshakes:
//   receiver side: kbd_nextdata_n is low for exactly the FETCH cycle in which
//     kbd_ready=1; the byte on kbd_data is taken at that clock edge. The FSM
//     always spends DECODE after a pop, so pops are never back-to-back.
//   consumer side: evt_valid rises with all evt_* fields and holds them stable;
//     the event is transferred on a clock edge where evt_valid && evt_ready.
//     evt_ready is ignored while evt_valid is low.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int E1_SKIP  = 7,
  parameter bit ASCII_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  input  logic       kbd_overflow,
  output logic       kbd_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] evt_ascii,
  output logic       shift,
  output logic       ctrl,
  output logic       alt,
  output logic       caps_lock,
  output logic       err,
  output logic       ovf_seen
);

  logic [1:0] state;
  logic [7:0] byte_q;
  logic       ext_flag;
  logic       brk_flag;
  logic [7:0] skip_cnt;
  logic       lshift_q;
  logic       rshift_q;
  logic       caps_held;
  logic [7:0] lut_ascii;
  kbd_evt_t   evt_q;

  assign shift          = lshift_q | rshift_q;
  assign kbd_nextdata_n = !((state == ST_FETCH) && kbd_ready && !rst);

  assign evt_code  = evt_q.code;
  assign evt_ext   = evt_q.ext;
  assign evt_break = evt_q.brk;
  assign evt_ascii = evt_q.ascii;

  // Translation sees modifier state from before the byte being decoded
  generate
    if (ASCII_EN) begin : g_lut
      ps2_ascii_lut u_lut (
        .code  (byte_q),
        .shift (shift),
        .caps  (caps_lock),
        .ascii (lut_ascii)
      );
    end else begin : g_no_lut
      assign lut_ascii = 8'h00;
    end
  endgenerate

  // Sequencer: fetch one byte, decode it, and hold an event until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      byte_q    <= 8'h00;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      skip_cnt  <= 8'h00;
      lshift_q  <= 1'b0;
      rshift_q  <= 1'b0;
      ctrl      <= 1'b0;
      alt       <= 1'b0;
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
      evt_q     <= '0;
      evt_valid <= 1'b0;
      err       <= 1'b0;
      ovf_seen  <= 1'b0;
    end else begin
      err <= 1'b0;
      if (kbd_overflow) begin
        ovf_seen <= 1'b1;
      end
      case (state)
        ST_FETCH: begin
          if (kbd_ready) begin
            byte_q <= kbd_data;
            state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= ST_FETCH;
          if (skip_cnt != 8'h00) begin
            // Remainder of the Pause sequence carries no key information
            skip_cnt <= skip_cnt - 8'h01;
          end else if (byte_q == SC_E1) begin
            skip_cnt  <= 8'(E1_SKIP);
            evt_q     <= '{code: SC_E1, ext: 1'b0, brk: 1'b0, ascii: 8'h00};
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            evt_valid <= 1'b1;
            state     <= ST_EMIT;
          end else if (byte_q == SC_E0) begin
            ext_flag <= 1'b1;
          end else if (byte_q == SC_F0) begin
            brk_flag <= 1'b1;
          end else if ((byte_q == SC_ERR0) || (byte_q == SC_ERR1)) begin
            err      <= 1'b1;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end else if ((byte_q == SC_BAT) && !ext_flag && !brk_flag) begin
            // Self-test completion from the keyboard, not a key
          end else begin
            evt_q.code  <= byte_q;
            evt_q.ext   <= ext_flag;
            evt_q.brk   <= brk_flag;
            evt_q.ascii <= (ext_flag || brk_flag) ? 8'h00 : lut_ascii;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            evt_valid   <= 1'b1;
            state       <= ST_EMIT;
            case (byte_q)
              SC_LSHIFT: lshift_q <= !brk_flag;
              SC_RSHIFT: rshift_q <= !brk_flag;
              SC_CTRL:   ctrl     <= !brk_flag;
              SC_ALT:    alt      <= !brk_flag;
              SC_CAPS: begin
                if (brk_flag) begin
                  caps_held <= 1'b0;
                end else begin
                  // Typematic repeats arrive with caps_held set and must not toggle
                  if (!caps_held) begin
                    caps_lock <= !caps_lock;
                  end
                  caps_held <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: a queue-based receiver FIFO model feeds bytes,
// expected events are queued as bytes are pushed and checked on handshake.
module tb_ps2_kbd_ctrl;
  import ps2_pkg::*;

  localparam int W = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_ready = 1'b0;
  logic       kbd_overflow = 1'b0;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] evt_ascii;
  logic       shift;
  logic       ctrl;
  logic       alt;
  logic       caps_lock;
  logic       err;
  logic       ovf_seen;

  ps2_kbd_ctrl #(.E1_SKIP(7), .ASCII_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_break      (evt_break),
    .evt_ascii      (evt_ascii),
    .shift          (shift),
    .ctrl           (ctrl),
    .alt            (alt),
    .caps_lock      (caps_lock),
    .err            (err),
    .ovf_seen       (ovf_seen)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;
  int b2b_cnt = 0;
  int err_cnt = 0;
  int evt_cnt = 0;
  bit pop_req = 1'b0;
  bit prev_low = 1'b0;

  logic [7:0]   fifo[$];
  logic [W-1:0] exp_q[$];

  // Receiver model: pop is requested in the low-strobe cycle, applied at the edge
  always @(negedge clk) begin
    if (!kbd_nextdata_n) begin
      pop_req = 1'b1;
      pop_cnt++;
      if (prev_low) b2b_cnt++;
    end
    prev_low = !kbd_nextdata_n;
  end

  always @(posedge clk) begin
    if (pop_req) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      pop_req = 1'b0;
    end
    if (fifo.size() > 0) begin
      kbd_ready <= 1'b1;
      kbd_data  <= fifo[0];
    end else begin
      kbd_ready <= 1'b0;
      kbd_data  <= 8'h00;
    end
  end

  // Scoreboard: compare each accepted event with the oldest expectation
  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (err) err_cnt++;
    if (evt_valid && evt_ready) begin
      evt_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL evt_unexpected: got code=%h ext=%b brk=%b ascii=%h, none expected",
                 evt_code, evt_ext, evt_break, evt_ascii);
      end else begin
        exp = exp_q.pop_front();
        if ({evt_code, evt_ext, evt_break, evt_ascii} !== exp) begin
          n_err++;
          $display("FAIL evt_%0d: got code=%h ext=%b brk=%b ascii=%h, want code=%h ext=%b brk=%b ascii=%h",
                   evt_cnt, evt_code, evt_ext, evt_break, evt_ascii,
                   exp[17:10], exp[9], exp[8], exp[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic expect_evt(input logic [7:0] c, input logic e, input logic k, input logic [7:0] a);
    exp_q.push_back({c, e, k, a});
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    evt_ready = v;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int quiet;
    bit done;
    quiet = 0;
    done  = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (fifo.size() == 0 && exp_q.size() == 0 && !evt_valid && kbd_nextdata_n) quiet++;
      else quiet = 0;
      if (quiet >= 4) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_%s: got fifo=%0d exp_left=%0d, want both 0", name, fifo.size(), exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [25:0] got;
    push(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0, 8'h61);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (kbd_nextdata_n !== 1'b1) begin
        n_err++;
        $display("FAIL reset_nopop: got nextdata_n=%b, want 1", kbd_nextdata_n);
      end
    end
    got = {kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
           shift, ctrl, alt, caps_lock, err, ovf_seen};
    n_cmp++;
    if (got !== 26'h2000000) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, want %h", got, 26'h2000000);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_ready(1'b1);
    wait_drain("reset");
  endtask

  task automatic test_basic();
    int p0;
    int b0;
    bit found;
    p0 = pop_cnt;
    b0 = b2b_cnt;
    push(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0, 8'h61);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!kbd_nextdata_n) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL basic_pop: got no pop within 20 cycles, want pop");
    end
    @(negedge clk);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_t1: got evt_valid=%b, want 0", evt_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (evt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL latency_t2: got evt_valid=%b, want 1", evt_valid);
    end
    push(8'hF0); push(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b1, 8'h00);
    wait_drain("basic");
    n_cmp++;
    if (pop_cnt - p0 != 3) begin
      n_err++;
      $display("FAIL basic_pops: got %0d, want 3", pop_cnt - p0);
    end
    n_cmp++;
    if (b2b_cnt != b0) begin
      n_err++;
      $display("FAIL basic_b2b: got %0d back-to-back pops, want 0", b2b_cnt - b0);
    end
  endtask

  task automatic test_modifiers();
    int e0;
    e0 = evt_cnt;
    push(8'h12);
    expect_evt(8'h12, 1'b0, 1'b0, 8'h00);
    wait_drain("lshift_make");
    n_cmp++;
    if (shift !== 1'b1) begin
      n_err++;
      $display("FAIL shift_set: got %b, want 1", shift);
    end
    push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
    expect_evt(8'h1C, 1'b0, 1'b0, 8'h41);
    expect_evt(8'h1C, 1'b0, 1'b1, 8'h00);
    expect_evt(8'h12, 1'b0, 1'b1, 8'h00);
    wait_drain("shift_seq");
    n_cmp++;
    if (shift !== 1'b0) begin
      n_err++;
      $display("FAIL shift_clear: got %b, want 0", shift);
    end
    n_cmp++;
    if (evt_cnt - e0 != 4) begin
      n_err++;
      $display("FAIL shift_evts: got %0d events, want 4", evt_cnt - e0);
    end
    push(8'h59); push(8'h16); push(8'hF0); push(8'h59); push(8'h16);
    expect_evt(8'h59, 1'b0, 1'b0, 8'h00);
    expect_evt(8'h16, 1'b0, 1'b0, 8'h21);
    expect_evt(8'h59, 1'b0, 1'b1, 8'h00);
    expect_evt(8'h16, 1'b0, 1'b0, 8'h31);
    push(8'h14); push(8'hE0); push(8'h11);
    expect_evt(8'h14, 1'b0, 1'b0, 8'h00);
    expect_evt(8'h11, 1'b1, 1'b0, 8'h00);
    wait_drain("ctrl_alt");
    n_cmp++;
    if ({ctrl, alt} !== 2'b11) begin
      n_err++;
      $display("FAIL ctrl_alt_set: got %b, want 11", {ctrl, alt});
    end
    push(8'h4E); push(8'hE0); push(8'hF0); push(8'h14); push(8'hF0); push(8'h11);
    push(8'hE0); push(8'h5A); push(8'h29);
    expect_evt(8'h4E, 1'b0, 1'b0, 8'h2D);
    expect_evt(8'h14, 1'b1, 1'b1, 8'h00);
    expect_evt(8'h11, 1'b0, 1'b1, 8'h00);
    expect_evt(8'h5A, 1'b1, 1'b0, 8'h00);
    expect_evt(8'h29, 1'b0, 1'b0, 8'h20);
    wait_drain("ctrl_alt_clr");
    n_cmp++;
    if ({ctrl, alt} !== 2'b00) begin
      n_err++;
      $display("FAIL ctrl_alt_clear: got %b, want 00", {ctrl, alt});
    end
  endtask

  task automatic test_prefixes();
    push(8'hE0); push(8'hF0); push(8'h75);
    expect_evt(8'h75, 1'b1, 1'b1, 8'h00);
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
    push(8'hF0); push(8'h14); push(8'hF0); push(8'h77); push(8'h1C);
    expect_evt(8'hE1, 1'b0, 1'b0, 8'h00);
    expect_evt(8'h1C, 1'b0, 1'b0, 8'h61);
    wait_drain("prefixes");
    n_cmp++;
    if (ctrl !== 1'b0) begin
      n_err++;
      $display("FAIL pause_ctrl: got %b, want 0", ctrl);
    end
  endtask

  task automatic test_caps();
    push(8'h58);
    expect_evt(8'h58, 1'b0, 1'b0, 8'h00);
    wait_drain("caps1");
    n_cmp++;
    if (caps_lock !== 1'b1) begin
      n_err++;
      $display("FAIL caps_on: got %b, want 1", caps_lock);
    end
    push(8'h1C); push(8'h16); push(8'h12); push(8'h1C); push(8'hF0); push(8'h12);
    expect_evt(8'h1C, 1'b0, 1'b0, 8'h41);
    expect_evt(8'h16, 1'b0, 1'b0, 8'h31);
    expect_evt(8'h12, 1'b0, 1'b0, 8'h00);
    expect_evt(8'h1C, 1'b0, 1'b0, 8'h61);
    expect_evt(8'h12, 1'b0, 1'b1, 8'h00);
    push(8'h58); push(8'h58); push(8'hF0); push(8'h58);
    expect_evt(8'h58, 1'b0, 1'b0, 8'h00);
    expect_evt(8'h58, 1'b0, 1'b0, 8'h00);
    expect_evt(8'h58, 1'b0, 1'b1, 8'h00);
    wait_drain("caps_rep");
    n_cmp++;
    if (caps_lock !== 1'b1) begin
      n_err++;
      $display("FAIL caps_repeat: got %b, want 1", caps_lock);
    end
    push(8'h58);
    expect_evt(8'h58, 1'b0, 1'b0, 8'h00);
    wait_drain("caps2");
    n_cmp++;
    if (caps_lock !== 1'b0) begin
      n_err++;
      $display("FAIL caps_off: got %b, want 0", caps_lock);
    end
    push(8'hF0); push(8'h58); push(8'h1C);
    expect_evt(8'h58, 1'b0, 1'b1, 8'h00);
    expect_evt(8'h1C, 1'b0, 1'b0, 8'h61);
    wait_drain("caps_end");
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [5];
    logic [7:0] ascii [5];
    bit found;
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    ascii = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    set_ready(1'b0);
    for (int i = 0; i < 5; i++) begin
      push(codes[i]);
      expect_evt(codes[i], 1'b0, 1'b0, ascii[i]);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (evt_valid) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL bp_first: got no evt_valid within 20 cycles, want 1");
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_code, evt_ascii, kbd_nextdata_n} !== {1'b1, 8'h1C, 8'h61, 1'b1}) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got valid=%b code=%h ascii=%h nextdata_n=%b, want 1 1c 61 1",
                 i, evt_valid, evt_code, evt_ascii, kbd_nextdata_n);
      end
    end
    n_cmp++;
    if (fifo.size() != 4) begin
      n_err++;
      $display("FAIL bp_fifo: got %0d bytes left, want 4", fifo.size());
    end
    set_ready(1'b1);
    wait_drain("backpressure");
  endtask

  task automatic test_errors();
    logic [25:0] got;
    int e0;
    bit found;
    push(8'hE0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!kbd_nextdata_n) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL e0_pop: got no pop within 20 cycles, want pop");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    got = {kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
           shift, ctrl, alt, caps_lock, err, ovf_seen};
    n_cmp++;
    if (got !== 26'h2000000) begin
      n_err++;
      $display("FAIL midreset_outputs: got %h, want %h", got, 26'h2000000);
    end
    push(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0, 8'h61);
    wait_drain("midreset");
    e0 = err_cnt;
    push(8'h00);
    wait_drain("err00");
    n_cmp++;
    if (err_cnt - e0 != 1) begin
      n_err++;
      $display("FAIL err00: got %0d err cycles, want 1", err_cnt - e0);
    end
    push(8'hFF); push(8'hF0); push(8'h00); push(8'h1C);
    push(8'hAA); push(8'hF0); push(8'hAA);
    expect_evt(8'h1C, 1'b0, 1'b0, 8'h61);
    expect_evt(8'hAA, 1'b0, 1'b1, 8'h00);
    wait_drain("errff");
    n_cmp++;
    if (err_cnt - e0 != 3) begin
      n_err++;
      $display("FAIL err_total: got %0d err cycles, want 3", err_cnt - e0);
    end
    n_cmp++;
    if (ovf_seen !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_idle: got %b, want 0", ovf_seen);
    end
    @(posedge clk); #1;
    kbd_overflow = 1'b1;
    @(posedge clk); #1;
    kbd_overflow = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (ovf_seen !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: got %b, want 1", ovf_seen);
    end
    pulse_rst();
    @(negedge clk);
    n_cmp++;
    if (ovf_seen !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_reset: got %b, want 0", ovf_seen);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_modifiers();
    test_prefixes();
    test_caps();
    test_back_to_back();
    test_errors();
    n_cmp++;
    if (b2b_cnt != 0) begin
      n_err++;
      $display("FAIL no_b2b_pops: got %0d, want 0", b2b_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
